game_sequencer: RTL
===================

// Module: game_sequencer
// PURPOSE
//  Top-level game FSM that sequences the ball datapath: serve, play, pause, miss, game over.
//  Sits between the board buttons and the ball/render logic.
//  - Drives the ball's reset and pause inputs.
//  - Generates the ball movement tick.
//  - Tracks lives and score from ball position and hit pulses.
// PARAMETERS
//  CLK_DIV      50000  CLOCK_50 cycles per movement tick (tick = 1-cycle pulse)
//  SERVE_DELAY  60     ticks spent in SERVE before the ball is released
//  LIVES        3      lives loaded at game start (1..3)
//  SCREEN_H     480    ball_y >= SCREEN_H means the ball left the field (miss)
//  SCORE_W      8      score width
// PORTS
//  CLOCK_50    in   1        system clock, 50 MHz
//  reset       in   1        asynchronous, active-low; 0 forces the reset state
//  start       in   1        start button, synchronous level; acted on at its rising edge
//  pause_btn   in   1        pause button, synchronous level; each rising edge toggles pause
//  ball_y      in   10       current ball y coordinate
//  ball_hit    in   1        1-cycle pulse: ball hit a target; +1 score
//  tick        out  1        1-cycle pulse every CLK_DIV cycles while counting
//  ball_reset  out  1        active-high; holds the ball at its start position
//  ball_pause  out  1        active-high; freezes ball movement
//  state       out  3        IDLE=0 SERVE=1 PLAY=2 PAUSED=3 LOST=4 OVER=5
//  lives       out  2        remaining lives
//  score       out  SCORE_W  current score, saturating
//  game_over   out  1        1 while in OVER
//  high_score  out  SCORE_W  best score; see CONFIGURATION
// BEHAVIOUR
//  Reset (reset=0)
//   - state=IDLE, tick=0, ball_reset=1, ball_pause=1.
//   - lives=0, score=0, game_over=0, high_score=0.
//   - Divider and serve counter cleared; edge-detect registers cleared.
//   - Applies immediately, from any state (including mid-PLAY).
//  Edge detect
//   - start_re and pause_re are registered rising edges: 1-cycle latency after the input rises.
//  Divider
//   - Counts 0..CLK_DIV-1 in SERVE and PLAY.
//   - tick=1 in the cycle the count equals CLK_DIV-1; the count then wraps to 0.
//   - Holds its value in PAUSED; cleared in IDLE, LOST and OVER.
//  IDLE
//   - ball_reset=1, ball_pause=1.
//   - On start_re: lives<=LIVES, score<=0, go to SERVE.
//  SERVE
//   - ball_reset=1, ball_pause=1.
//   - The serve counter increments on each tick.
//   - On the SERVE_DELAY-th tick: counter<=0, go to PLAY.
//  PLAY
//   - ball_reset=0, ball_pause=0.
//   - ball_hit: score+1; saturates at all-ones.
//   - ball_y>=SCREEN_H: go to LOST.
//   - Otherwise, pause_re: go to PAUSED.
//  PAUSED
//   - ball_pause=1, ball_reset=0; ball_hit is ignored.
//   - pause_re: go to PLAY.
//  LOST (one cycle)
//   - lives<=lives-1.
//   - If lives was 1: go to OVER; otherwise go to SERVE.
//  OVER
//   - game_over=1, ball_reset=1, ball_pause=1; lives=0, score held.
//   - On start_re: reload as in IDLE and go to SERVE.
//  Simultaneous events in PLAY
//   - Miss and pause_re: miss wins, pause_re is discarded.
//   - Miss and ball_hit: the hit is still counted.
//  start_re is ignored in SERVE, PLAY, PAUSED and LOST.
//  Outputs ball_reset, ball_pause and game_over are registered: valid from the first cycle in each state.
//  Undefined state encodings recover to IDLE.
// CONFIGURATION
//  HIGH_SCORE_EN defined
//   - On the LOST->OVER transition: if score>high_score, high_score<=score.
//   - high_score survives start and is cleared only by reset.
//  HIGH_SCORE_EN undefined
//   - high_score is tied to 0; no register is synthesized.
// TESTING  (CLK_DIV=4, SERVE_DELAY=2, LIVES=3)
//  - reset=0 during PLAY -> same cycle: state=0, ball_reset=1, score=0, lives=0, tick=0.
//  - start pulse from IDLE -> lives=3, state=1; PLAY after 8 cycles in SERVE; tick every 4th cycle.
//  - 3 ball_hit pulses in PLAY, then ball_y=480 -> score=3, LOST for 1 cycle, lives=2, state=SERVE.
//  - pause_btn edge in PLAY, hold 10 cycles, edge again -> ball_pause=1 for the interval, no tick, divider resumes from held count.
//  - ball_y=500 with pause_re in same cycle -> state=LOST, not PAUSED; ball_hit with miss -> counted.
//  - 3 misses with score=5 -> state=OVER, game_over=1, lives=0; HIGH_SCORE_EN: high_score=5; start -> SERVE, score=0, high_score=5.

Source files
------------

// File: rtl/game_sequencer.sv
// ============================================================================
//  Module   : game_sequencer
//  Purpose  : Top-level game FSM sequencing the ball datapath through serve,
//             play, pause, miss and game-over. Drives the ball reset/pause
//             controls, generates the ball movement tick and keeps lives and
//             score from ball position and hit pulses.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLOCK_50   in   1        system clock
//    reset      in   1        asynchronous, active-low
//    start      in   1        start button level (acted on at rising edge)
//    pause_btn  in   1        pause button level (rising edge toggles pause)
//    ball_y     in   10       ball y coordinate
//    ball_hit   in   1        1-cycle pulse, ball hit a target (+1 score)
//    tick       out  1        1-cycle movement pulse every CLK_DIV cycles
//    ball_reset out  1        holds the ball at its start position
//    ball_pause out  1        freezes ball movement
//    state      out  3        IDLE=0 SERVE=1 PLAY=2 PAUSED=3 LOST=4 OVER=5
//    lives      out  2        remaining lives
//    score      out  SCORE_W  current score, saturating
//    game_over  out  1        high while in OVER
//    high_score out  SCORE_W  best score (0 unless HIGH_SCORE_EN)
//  Build option
//    HIGH_SCORE_EN : when defined, keeps a high-score register updated on
//                    the LOST->OVER transition; otherwise high_score is 0.
// ============================================================================
`default_nettype none

module game_sequencer #(
    parameter int CLK_DIV     = 50000,
    parameter int SERVE_DELAY = 60,
    parameter int LIVES       = 3,
    parameter int SCREEN_H    = 480,
    parameter int SCORE_W     = 8
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               start,
    input  logic               pause_btn,
    input  logic [9:0]         ball_y,
    input  logic               ball_hit,
    output logic               tick,
    output logic               ball_reset,
    output logic               ball_pause,
    output logic [2:0]         state,
    output logic [1:0]         lives,
    output logic [SCORE_W-1:0] score,
    output logic               game_over,
    output logic [SCORE_W-1:0] high_score
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SRV_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [SRV_W-1:0] SRV_LAST   = SRV_W'(SERVE_DELAY - 1);
    localparam logic [9:0]       Y_LIMIT    = 10'(SCREEN_H);
    localparam logic [1:0]       LIVES_INIT = 2'(LIVES);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SERVE  = 3'd1,
        S_PLAY   = 3'd2,
        S_PAUSED = 3'd3,
        S_LOST   = 3'd4,
        S_OVER   = 3'd5
    } state_t;

    state_t           st;
    logic [DIV_W-1:0] div_cnt;
    logic [SRV_W-1:0] serve_cnt;
    logic             start_q;
    logic             pause_q;
    logic             start_re;
    logic             pause_re;
    logic             counting;
    logic             miss;

    assign state    = st;
    assign counting = (st == S_SERVE) || (st == S_PLAY);
    assign tick     = counting && (div_cnt == DIV_LAST);
    assign miss     = (ball_y >= Y_LIMIT);

    // Registered rising-edge detectors for the two buttons.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            start_q  <= 1'b0;
            pause_q  <= 1'b0;
            start_re <= 1'b0;
            pause_re <= 1'b0;
        end else begin
            start_q  <= start;
            pause_q  <= pause_btn;
            start_re <= start & ~start_q;
            pause_re <= pause_btn & ~pause_q;
        end
    end

    // Movement divider: runs in SERVE/PLAY, freezes in PAUSED so play resumes
    // mid-period, and is zeroed everywhere else.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (counting) begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
        end else if (st != S_PAUSED) begin
            div_cnt <= '0;
        end
    end

    // Game FSM. Ball controls and game_over are assigned alongside each
    // transition so they are correct from the first cycle of the new state.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            st         <= S_IDLE;
            serve_cnt  <= '0;
            lives      <= 2'd0;
            score      <= '0;
            ball_reset <= 1'b1;
            ball_pause <= 1'b1;
            game_over  <= 1'b0;
        end else begin
            case (st)
                S_IDLE, S_OVER: begin
                    if (start_re) begin
                        st         <= S_SERVE;
                        lives      <= LIVES_INIT;
                        score      <= '0;
                        serve_cnt  <= '0;
                        ball_reset <= 1'b1;
                        ball_pause <= 1'b1;
                        game_over  <= 1'b0;
                    end
                end
                S_SERVE: begin
                    if (tick) begin
                        if (serve_cnt == SRV_LAST) begin
                            serve_cnt  <= '0;
                            st         <= S_PLAY;
                            ball_reset <= 1'b0;
                            ball_pause <= 1'b0;
                        end else begin
                            serve_cnt <= serve_cnt + 1'b1;
                        end
                    end
                end
                S_PLAY: begin
                    // A hit coinciding with a miss still scores.
                    if (ball_hit && (score != '1)) begin
                        score <= score + 1'b1;
                    end
                    // Miss takes priority; a simultaneous pause edge is dropped.
                    if (miss) begin
                        st         <= S_LOST;
                        ball_reset <= 1'b1;
                        ball_pause <= 1'b1;
                    end else if (pause_re) begin
                        st         <= S_PAUSED;
                        ball_pause <= 1'b1;
                    end
                end
                S_PAUSED: begin
                    if (pause_re) begin
                        st         <= S_PLAY;
                        ball_pause <= 1'b0;
                    end
                end
                S_LOST: begin
                    ball_reset <= 1'b1;
                    ball_pause <= 1'b1;
                    if (lives <= 2'd1) begin
                        lives     <= 2'd0;
                        st        <= S_OVER;
                        game_over <= 1'b1;
                    end else begin
                        lives <= lives - 2'd1;
                        st    <= S_SERVE;
                    end
                end
                default: begin
                    st         <= S_IDLE;
                    serve_cnt  <= '0;
                    ball_reset <= 1'b1;
                    ball_pause <= 1'b1;
                    game_over  <= 1'b0;
                end
            endcase
        end
    end

`ifdef HIGH_SCORE_EN
    logic [SCORE_W-1:0] best;

    // Updated only when the final life is lost; survives restarts.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            best <= '0;
        end else if ((st == S_LOST) && (lives <= 2'd1) && (score > best)) begin
            best <= score;
        end
    end

    assign high_score = best;
`else
    assign high_score = '0;
`endif

endmodule

`default_nettype wire
